// File: rtl/mem_wait_responder_if.sv
// Bus between a processor and the wait-state memory responder.
// Handshake: the master raises memread and/or memwrite with dataadr and
// writedata for one or more cycles. The responder samples them only while
// idle. Once it accepts a request, the inputs are ignored until the
// response completes. ready is a single-cycle strobe that ends the access.
// readdata and err are meaningful only in that ready cycle.
interface mem_wait_responder_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
    logic        err;
    logic        done;
    logic [15:0] wrcount;

    modport master (
        output memread, memwrite, dataadr, writedata,
        input  readdata, ready, err, done, wrcount
    );

    modport slave (
        input  memread, memwrite, dataadr, writedata,
        output readdata, ready, err, done, wrcount
    );
endinterface

// File: rtl/mem_wait_responder.sv
// Word-addressed memory responder with a fixed number of wait states per
// access. It flags misaligned, out-of-range and ambiguous requests. It keeps
// a saturating count of committed writes and a sticky completion flag that
// is set by one magic write.
module mem_wait_responder #(
    parameter int unsigned MEMWORDS    = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] DONE_ADR    = 32'd84,
    parameter logic [31:0] DONE_DATA   = 32'd7
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_wait_responder_if.slave   bus,
    output logic [1:0]            dbg_state_o
);
    localparam int unsigned AW        = $clog2(MEMWORDS);
    localparam logic [31:0] LIMIT     = 32'(4 * MEMWORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [31:0]    adr_q, adr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           wr_q, wr_d;
    logic           err_q, err_d;
    logic           done_q;
    logic [15:0]    wrcount_q;
    logic [31:0]    mem_q [MEMWORDS];

    logic           req;
    logic           req_err;
    logic           commit;
    logic [AW-1:0]  idx;

    assign req     = bus.memread | bus.memwrite;
    // Errors are decided from the request as it is accepted, then held.
    assign req_err = (bus.dataadr[1:0] != 2'b00) || (bus.dataadr >= LIMIT) ||
                     (bus.memread && bus.memwrite);
    assign idx     = adr_q[AW+1:2];
    // A write commits at the edge that ends RESP, and only if it was legal.
    assign commit  = (state_q == RESP) && wr_q && !err_q;

    // State, wait counter and latched request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    // Next state: accept only in IDLE, count down the wait states, then respond once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    adr_d   = bus.dataadr;
                    wdata_d = bus.writedata;
                    wr_d    = bus.memwrite;
                    err_d   = req_err;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Completion flag and saturating write counter track committed writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q    <= 1'b0;
            wrcount_q <= 16'd0;
        end else if (commit) begin
            if (wrcount_q != 16'hFFFF) begin
                wrcount_q <= wrcount_q + 16'd1;
            end
            if ((adr_q == DONE_ADR) && (wdata_q == DONE_DATA)) begin
                done_q <= 1'b1;
            end
        end
    end

    // Memory array keeps its contents through reset; an aborted access never reaches RESP.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[idx] <= wdata_q;
        end
    end

    // Response outputs: ready/err only in RESP, read data only for a legal read.
    always_comb begin
        bus.ready    = (state_q == RESP);
        bus.err      = (state_q == RESP) && err_q;
        bus.readdata = 32'd0;
        if ((state_q == RESP) && !wr_q && !err_q) begin
            bus.readdata = mem_q[idx];
        end
    end

    assign bus.done    = done_q;
    assign bus.wrcount = wrcount_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: two instances (2 and 0 wait states)
// share clock and reset; a table of single accesses plus hand sequences for
// input ignoring, back-to-back spacing, reset abort and near-miss done writes.
module tb_mem_wait_responder;
    logic clk = 1'b0;
    logic reset;
    logic sel;      // 0 selects the 2-wait instance, 1 the 0-wait instance
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_wait_responder_if if2();
    mem_wait_responder_if if0();
    logic [1:0] st2;
    logic [1:0] st0;

    mem_wait_responder #(
        .MEMWORDS(64), .WAIT_STATES(2), .DONE_ADR(32'd84), .DONE_DATA(32'd7)
    ) dut_w2 (
        .clk(clk), .reset(reset), .bus(if2), .dbg_state_o(st2)
    );

    mem_wait_responder #(
        .MEMWORDS(64), .WAIT_STATES(0), .DONE_ADR(32'd84), .DONE_DATA(32'd7)
    ) dut_w0 (
        .clk(clk), .reset(reset), .bus(if0), .dbg_state_o(st0)
    );

    logic        s_ready, s_err, s_done;
    logic [31:0] s_rdata;
    logic [15:0] s_wrc;
    logic [1:0]  s_state;

    assign s_ready = sel ? if0.ready    : if2.ready;
    assign s_err   = sel ? if0.err      : if2.err;
    assign s_done  = sel ? if0.done     : if2.done;
    assign s_rdata = sel ? if0.readdata : if2.readdata;
    assign s_wrc   = sel ? if0.wrcount  : if2.wrcount;
    assign s_state = sel ? st0          : st2;

    typedef struct {
        bit          sel;
        bit          rd;
        bit          wr;
        logic [31:0] adr;
        logic [31:0] wd;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [15:0] exp_wrc;
        bit          exp_done;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            if0.memread   = rd;
            if0.memwrite  = wr;
            if0.dataadr   = a;
            if0.writedata = d;
        end else begin
            if2.memread   = rd;
            if2.memwrite  = wr;
            if2.dataadr   = a;
            if2.writedata = d;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_ready"}, 32'(s_ready), 32'd0);
        check({name, "_err"},   32'(s_err),   32'd0);
        check({name, "_rdata"}, s_rdata,      32'd0);
        check({name, "_done"},  32'(s_done),  32'd0);
        check({name, "_wrc"},   32'(s_wrc),   32'd0);
        check({name, "_state"}, 32'(s_state), 32'd0);
    endtask

    // One complete access; called just after an edge with the selected DUT idle.
    task automatic do_access(input string name, input bit rd, input bit wr,
                             input logic [31:0] a, input logic [31:0] d,
                             input bit exp_err, input logic [31:0] exp_rd);
        int lat;
        int exp_lat;
        exp_lat = sel ? 0 : 2;
        drive(rd, wr, a, d);
        tick();                 // request accepted at this edge
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        lat = 0;
        while (!s_ready && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_ready"}, 32'(s_ready), 32'd1);
        check({name, "_lat"},   32'(lat),     32'(exp_lat));
        check({name, "_err"},   32'(s_err),   32'(exp_err));
        check({name, "_rdata"}, s_rdata,      exp_rd);
        tick();
        check({name, "_ready_off"}, 32'(s_ready), 32'd0);
        check({name, "_err_off"},   32'(s_err),   32'd0);
        check({name, "_rdata_off"}, s_rdata,      32'd0);
    endtask

    initial begin
        int r_cnt;
        int r_pos [3];

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'd84,  32'd7,        1'b0, 32'h0,         16'd1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'd20,  32'h1234_5678, 1'b0, 32'h0,        16'd2, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd20,  32'h0,        1'b0, 32'h1234_5678, 16'd2, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'd256, 32'h55,       1'b1, 32'h0,         16'd2, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'd6,   32'h55,       1'b1, 32'h0,         16'd2, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'd20,  32'hAAAA_5555, 1'b1, 32'h0,        16'd2, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd20,  32'h0,        1'b0, 32'h1234_5678, 16'd2, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'd252, 32'hCAFE_0001, 1'b0, 32'h0,        16'd3, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'd252, 32'h0,        1'b0, 32'hCAFE_0001, 16'd3, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'd256, 32'h0,        1'b1, 32'h0,         16'd3, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'd22,  32'h0,        1'b1, 32'h0,         16'd3, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'd8,   32'hDEAD_BEEF, 1'b0, 32'h0,        16'd1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'd8,   32'h0,        1'b0, 32'hDEAD_BEEF, 16'd1, 1'b0};

        // Clock/reset: reset held for 22 time units, all requests idle.
        reset = 1'b1;
        sel   = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        sel   = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #21;
        sel = 1'b0;
        #0 check_reset_state("rst_w2");
        sel = 1'b1;
        #0 check_reset_state("rst_w0");
        sel = 1'b0;
        #1 reset = 1'b0;

        // Table of single accesses; the first is accepted at the first edge out of reset.
        for (int i = 0; i < 13; i++) begin
            sel = vecs[i].sel;
            do_access($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].wd,
                      vecs[i].exp_err, vecs[i].exp_rd);
            check($sformatf("v%0d_wrc", i),  32'(s_wrc),  32'(vecs[i].exp_wrc));
            check($sformatf("v%0d_done", i), 32'(s_done), 32'(vecs[i].exp_done));
        end

        // Inputs change while waiting: the latched read of word 5 must win, no write happens.
        sel = 1'b0;
        drive(1'b1, 1'b0, 32'd20, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'd252, 32'h0BAD_0BAD);
        tick();
        check("ign_wait_ready", 32'(s_ready), 32'd0);
        tick();
        check("ign_ready", 32'(s_ready), 32'd1);
        check("ign_rdata", s_rdata, 32'h1234_5678);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("ign_ready_off", 32'(s_ready), 32'd0);
        check("ign_wrc", 32'(s_wrc), 32'd3);
        do_access("ign_rb", 1'b1, 1'b0, 32'd252, 32'd0, 1'b0, 32'hCAFE_0001);

        // Request held high continuously: ready pulses spaced WAIT_STATES+2 = 4 edges.
        r_cnt = 0;
        r_pos[0] = -1;
        r_pos[1] = -1;
        r_pos[2] = -1;
        drive(1'b1, 1'b0, 32'd20, 32'd0);
        for (int t = 0; t < 12; t++) begin
            tick();
            if (s_ready) begin
                if (r_cnt < 3) r_pos[r_cnt] = t;
                r_cnt++;
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        check("b2b_count", 32'(r_cnt), 32'd3);
        check("b2b_first", 32'(r_pos[0]), 32'd2);
        check("b2b_second", 32'(r_pos[1]), 32'd6);
        tick();

        // Reset mid-cycle clears everything immediately.
        reset = 1'b1;
        #1 check_reset_state("rst2_w2");
        tick();
        reset = 1'b0;

        // Reset during WAIT aborts a done-write; word 21 keeps its prior value.
        do_access("pre21", 1'b0, 1'b1, 32'd84, 32'h1111_1111, 1'b0, 32'h0);
        check("pre21_wrc", 32'(s_wrc), 32'd1);
        check("pre21_done", 32'(s_done), 32'd0);
        drive(1'b0, 1'b1, 32'd84, 32'd7);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("abort_in_wait", 32'(s_state), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_state("abort");
        tick();
        reset = 1'b0;
        tick();
        check("abort_done_later", 32'(s_done), 32'd0);
        do_access("abort_rb", 1'b1, 1'b0, 32'd84, 32'd0, 1'b0, 32'h1111_1111);
        check("abort_wrc", 32'(s_wrc), 32'd0);

        // Near-miss completion writes: right address wrong data, right data wrong address.
        do_access("nm1", 1'b0, 1'b1, 32'd84, 32'd6, 1'b0, 32'h0);
        check("nm1_done", 32'(s_done), 32'd0);
        do_access("nm2", 1'b0, 1'b1, 32'd80, 32'd7, 1'b0, 32'h0);
        check("nm2_done", 32'(s_done), 32'd0);
        check("nm2_wrc", 32'(s_wrc), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_wait_responder.md
MEM_WAIT_RESPONDER -- requirements
Module: mem_wait_responder

Interface
REQ-001 SHALL have parameter MEMWORDS, default 64, number of 32-bit memory words (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_STATES, default 2, wait cycles inserted per access (0..15).
REQ-003 SHALL have parameter DONE_ADR, default 84, byte address of the completion write.
REQ-004 SHALL have parameter DONE_DATA, default 7, data value of the completion write.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port memread, input, 1, processor read request.
REQ-008 SHALL have port memwrite, input, 1, processor write request.
REQ-009 SHALL have port dataadr, input, 32, byte address of the request.
REQ-010 SHALL have port writedata, input, 32, write data.
REQ-011 SHALL have port readdata, output, 32, read data, valid only while ready=1.
REQ-012 SHALL have port ready, output, 1, one-cycle access-complete strobe.
REQ-013 SHALL have port err, output, 1, one-cycle error strobe, coincident with ready.
REQ-014 SHALL have port done, output, 1, sticky completion flag.
REQ-015 SHALL have port wrcount, output, 16, count of committed writes.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE, at a rising edge with memread|memwrite=1, SHALL latch dataadr, writedata and operation; go to WAIT with counter=WAIT_STATES, or straight to RESP if WAIT_STATES=0.
REQ-018 In WAIT, SHALL decrement the counter each edge; at the edge where the counter equals 1, go to RESP.
REQ-019 In RESP, SHALL drive ready=1 for exactly one cycle, then return to IDLE.
REQ-020 Latency: request sampled at edge E0 -> ready high between edges E0+WAIT_STATES and E0+WAIT_STATES+1.
REQ-021 Request inputs SHALL be ignored in WAIT and RESP; only latched values are used.
REQ-022 A new request SHALL be accepted no earlier than the edge following the RESP cycle, i.e. back-to-back accesses are spaced WAIT_STATES+2 cycles.
REQ-023 Word index SHALL be latched dataadr[log2(MEMWORDS)+1:2].
REQ-024 Read: readdata SHALL equal the addressed word during RESP; readdata SHALL be 0 outside RESP.
REQ-025 Write: the addressed word SHALL be updated at the edge ending RESP; a read of the same word afterwards returns the new value.
REQ-026 Error cases: dataadr[1:0]!=0, dataadr>=4*MEMWORDS, or memread and memwrite both 1 at acceptance.
REQ-027 On error: RESP still occurs with ready=1, err=1, readdata=0, no memory write, wrcount unchanged.
REQ-028 A committed write with latched address DONE_ADR and data DONE_DATA SHALL set done at the same edge; done stays 1 until reset.
REQ-029 wrcount SHALL increment by 1 at each committed non-error write and saturate at 16'hFFFF.
REQ-030 Memory array contents SHALL NOT be cleared by reset; the bench preloads them.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, counter 0, ready=0, err=0, readdata=0, done=0, wrcount=0.
REQ-032 Reset during WAIT or RESP SHALL abort the access; no memory write occurs from the aborted access.
REQ-033 First request SHALL be accepted at the first rising edge with reset=0.

Verification
REQ-034 Reset for 22 time units, memwrite=1 adr=84 data=7 for one cycle (W=2) -> ready one cycle 3 edges later, done=1 thereafter, wrcount=1.
REQ-035 Preload word 5=32'h1234_5678, memread adr=20 (W=2) -> ready=1, readdata=32'h1234_5678 in that cycle only, err=0.
REQ-036 W=0: write adr=8 data=32'hDEAD_BEEF then read adr=8 -> each ready one cycle after request edge; read returns 32'hDEAD_BEEF.
REQ-037 memwrite adr=256 (MEMWORDS=64), then adr=6, then memread+memwrite together -> each gives ready=1 err=1, readdata=0, wrcount unchanged, memory unchanged.
REQ-038 Write adr=84 data=7, assert reset during WAIT -> done=0, wrcount=0, word 21 unchanged, FSM in IDLE.
REQ-039 Write adr=84 data=6 then adr=80 data=7 -> done stays 0; wrcount=2.
